// File: rtl/axi_txn_arbiter.sv
// axi_txn_arbiter: shares one single-beat AXI4 master between two requesters.
// One transaction is in flight at a time. Grant is round-robin by default;
// defining AXI_TXN_ARB_FIXED_PRIO_EN makes req0 always win.
module axi_txn_arbiter #(
   parameter int AW = 64,
   parameter int DW = 64,
   parameter int IW = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   // requester 0 command / response
   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic            req0_we_i,
   input  logic [AW-1:0]   req0_addr_i,
   input  logic [DW-1:0]   req0_wdata_i,
   input  logic [DW/8-1:0] req0_wstrb_i,
   output logic            rsp0_valid_o,
   output logic [DW-1:0]   rsp0_rdata_o,
   output logic            rsp0_err_o,
   // requester 1 command / response
   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic            req1_we_i,
   input  logic [AW-1:0]   req1_addr_i,
   input  logic [DW-1:0]   req1_wdata_i,
   input  logic [DW/8-1:0] req1_wstrb_i,
   output logic            rsp1_valid_o,
   output logic [DW-1:0]   rsp1_rdata_o,
   output logic            rsp1_err_o,
   // AXI4 write address / data
   output logic            m_aw_valid_o,
   input  logic            m_aw_ready_i,
   output logic [AW-1:0]   m_aw_addr_o,
   output logic [IW-1:0]   m_aw_id_o,
   output logic [7:0]      m_aw_len_o,
   output logic [2:0]      m_aw_size_o,
   output logic [1:0]      m_aw_burst_o,
   output logic            m_w_valid_o,
   input  logic            m_w_ready_i,
   output logic [DW-1:0]   m_w_data_o,
   output logic [DW/8-1:0] m_w_strb_o,
   output logic            m_w_last_o,
   // AXI4 write response
   input  logic            m_b_valid_i,
   output logic            m_b_ready_o,
   input  logic [1:0]      m_b_resp_i,
   // AXI4 read address / data
   output logic            m_ar_valid_o,
   input  logic            m_ar_ready_i,
   output logic [AW-1:0]   m_ar_addr_o,
   output logic [IW-1:0]   m_ar_id_o,
   output logic [7:0]      m_ar_len_o,
   output logic [2:0]      m_ar_size_o,
   output logic [1:0]      m_ar_burst_o,
   input  logic            m_r_valid_i,
   output logic            m_r_ready_o,
   input  logic [DW-1:0]   m_r_data_i,
   input  logic [1:0]      m_r_resp_i,
   input  logic            m_r_last_i
);

   localparam int         SW     = DW / 8;
   localparam logic [2:0] AXSIZE = 3'($clog2(SW));
   localparam logic [1:0] INCR   = 2'b01;

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
   } state_t;

   state_t          state_reg, state_next;
   logic            last_grant_reg, last_grant_next;
   logic            idx_reg, idx_next;
   logic [AW-1:0]   addr_reg, addr_next;
   logic [DW-1:0]   wdata_reg, wdata_next;
   logic [SW-1:0]   wstrb_reg, wstrb_next;
   logic            aw_done_reg, aw_done_next;
   logic            w_done_reg, w_done_next;
   logic [DW-1:0]   rdata_reg, rdata_next;
   logic            err_reg, err_next;

   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [1:0]      rsp_valid;
   logic            grant_any;
   logic            grant_idx;
   logic            accept;

   // Status bits the design deliberately ignores (LSB of resp, r_last).
   logic            unused_ok;
   assign unused_ok = &{1'b0, m_b_resp_i[0], m_r_resp_i[0], m_r_last_i, last_grant_reg};

   assign req_valid = {req1_valid_i, req0_valid_i};
   assign accept    = (state_reg == IDLE) && grant_any;

   // Pick the requester to be offered ready this cycle.
   always_comb begin
      grant_any = |req_valid;
`ifdef AXI_TXN_ARB_FIXED_PRIO_EN
      grant_idx = ~req_valid[0];
`else
      if (req_valid == 2'b11) grant_idx = ~last_grant_reg;
      else                    grant_idx = ~req_valid[0];
`endif
   end

   // Per-requester ready and response-valid decode.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         // Ready is masked during reset so every output reads 0 while rst_ni is low.
         assign req_ready[gi] = rst_ni && accept && (grant_idx == 1'(gi));
         assign rsp_valid[gi] = (state_reg == DONE) && (idx_reg == 1'(gi));
      end
   endgenerate

   // Next-state and capture logic for the transaction FSM.
   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      idx_next        = idx_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      wstrb_next      = wstrb_reg;
      aw_done_next    = aw_done_reg;
      w_done_next     = w_done_reg;
      rdata_next      = rdata_reg;
      err_next        = err_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               idx_next        = grant_idx;
               last_grant_next = grant_idx;
               addr_next       = grant_idx ? req1_addr_i  : req0_addr_i;
               wdata_next      = grant_idx ? req1_wdata_i : req0_wdata_i;
               wstrb_next      = grant_idx ? req1_wstrb_i : req0_wstrb_i;
               aw_done_next    = 1'b0;
               w_done_next     = 1'b0;
               rdata_next      = '0;
               err_next        = 1'b0;
               if (grant_idx ? req1_we_i : req0_we_i) state_next = WR_REQ;
               else                                    state_next = RD_REQ;
            end
         end
         WR_REQ: begin
            // AW and W complete independently; B is only awaited after both.
            aw_done_next = aw_done_reg | m_aw_ready_i;
            w_done_next  = w_done_reg  | m_w_ready_i;
            if (aw_done_next && w_done_next) state_next = WR_RESP;
         end
         WR_RESP: begin
            if (m_b_valid_i) begin
               err_next   = m_b_resp_i[1];
               state_next = DONE;
            end
         end
         RD_REQ: begin
            if (m_ar_ready_i) state_next = RD_RESP;
         end
         RD_RESP: begin
            if (m_r_valid_i) begin
               rdata_next = m_r_data_i;
               err_next   = m_r_resp_i[1];
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State and captured-request registers; reset clears everything asynchronously.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         idx_reg        <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         wstrb_reg      <= '0;
         aw_done_reg    <= 1'b0;
         w_done_reg     <= 1'b0;
         rdata_reg      <= '0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         idx_reg        <= idx_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         wstrb_reg      <= wstrb_next;
         aw_done_reg    <= aw_done_next;
         w_done_reg     <= w_done_next;
         rdata_reg      <= rdata_next;
         err_reg        <= err_next;
      end
   end

   assign req0_ready_o = req_ready[0];
   assign req1_ready_o = req_ready[1];

   assign rsp0_valid_o = rsp_valid[0];
   assign rsp1_valid_o = rsp_valid[1];
   assign rsp0_rdata_o = rsp_valid[0] ? rdata_reg : '0;
   assign rsp1_rdata_o = rsp_valid[1] ? rdata_reg : '0;
   assign rsp0_err_o   = rsp_valid[0] & err_reg;
   assign rsp1_err_o   = rsp_valid[1] & err_reg;

   // Fixed burst attributes are shown only alongside their valid so reset reads all-zero.
   assign m_aw_valid_o = (state_reg == WR_REQ) && !aw_done_reg;
   assign m_aw_addr_o  = addr_reg;
   assign m_aw_id_o    = IW'(idx_reg);
   assign m_aw_len_o   = 8'd0;
   assign m_aw_size_o  = m_aw_valid_o ? AXSIZE : 3'd0;
   assign m_aw_burst_o = m_aw_valid_o ? INCR : 2'b00;

   assign m_w_valid_o  = (state_reg == WR_REQ) && !w_done_reg;
   assign m_w_data_o   = wdata_reg;
   assign m_w_strb_o   = wstrb_reg;
   assign m_w_last_o   = m_w_valid_o;

   assign m_b_ready_o  = (state_reg == WR_RESP);

   assign m_ar_valid_o = (state_reg == RD_REQ);
   assign m_ar_addr_o  = addr_reg;
   assign m_ar_id_o    = IW'(idx_reg);
   assign m_ar_len_o   = 8'd0;
   assign m_ar_size_o  = m_ar_valid_o ? AXSIZE : 3'd0;
   assign m_ar_burst_o = m_ar_valid_o ? INCR : 2'b00;

   assign m_r_ready_o  = (state_reg == RD_RESP);

endmodule

// File: doc/axi_txn_arbiter.md
AXI_TXN_ARBITER -- requirements
Module: axi_txn_arbiter

Interface
REQ-001 SHALL have parameter AW, default 64, AXI/request address width.
REQ-002 SHALL have parameter DW, default 64, data width; DW/8 strobe bits.
REQ-003 SHALL have parameter IW, default 8, AXI ID width, at least 1.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have, for N in {0,1}: reqN_valid_i in 1, reqN_ready_o out 1, reqN_we_i in 1, reqN_addr_i in AW, reqN_wdata_i in DW, reqN_wstrb_i in DW/8; this is the requester command.
REQ-007 SHALL have, for N in {0,1}: rspN_valid_o out 1, rspN_rdata_o out DW, rspN_err_o out 1; this is the requester response, with no backpressure.
REQ-008 SHALL have AXI4 master AW/W ports: m_aw_valid_o, m_aw_ready_i, m_aw_addr_o (AW), m_aw_id_o (IW), m_aw_len_o (8), m_aw_size_o (3), m_aw_burst_o (2); m_w_valid_o, m_w_ready_i, m_w_data_o (DW), m_w_strb_o (DW/8), m_w_last_o.
REQ-009 SHALL have AXI4 master B/AR/R ports: m_b_valid_i, m_b_ready_o, m_b_resp_i (2); m_ar_valid_o, m_ar_ready_i, m_ar_addr_o, m_ar_id_o, m_ar_len_o, m_ar_size_o, m_ar_burst_o; m_r_valid_i, m_r_ready_o, m_r_data_i (DW), m_r_resp_i (2), m_r_last_i.

Function
REQ-010 SHALL share one AXI4 master between two requesters, with one outstanding transaction and a single beat per transaction.
REQ-011 SHALL implement the FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP and DONE.
REQ-012 IDLE SHALL assert reqN_ready_o combinationally only for the granted requester; on valid&&ready it SHALL register addr/we/wdata/wstrb/index and go to WR_REQ if we=1, else RD_REQ.
REQ-013 Grant SHALL be round-robin: a sole requester wins, and when both request the one not granted last wins; the last-grant pointer resets to 1, so req0 wins the first tie.
REQ-014 WR_REQ SHALL assert m_aw_valid_o and m_w_valid_o from the cycle after acceptance, drop each independently on its handshake, and enter WR_RESP once both have completed, in either order or in the same cycle.
REQ-015 WR_RESP SHALL hold m_b_ready_o=1, and on m_b_valid_i SHALL go to DONE with err=m_b_resp_i[1].
REQ-016 RD_REQ SHALL assert m_ar_valid_o until m_ar_ready_i, then enter RD_RESP, which SHALL hold m_r_ready_o=1 and on m_r_valid_i capture data and err=m_r_resp_i[1], then go to DONE.
REQ-017 DONE SHALL pulse rspN_valid_o for exactly one cycle for the owning requester, then return to IDLE; rdata SHALL be 0 for writes.
REQ-018 Latency with a zero-wait slave SHALL be: accept at T, AW/AR at T+1, B/R at T+2, rsp_valid at T+3, next accept at T+4.
REQ-019 The block SHALL drive len=0, size=log2(DW/8), burst=INCR(01), w_last=1, and id = {IW-1 zeros, requester index}.
REQ-020 A valid SHALL never be deasserted before its handshake, and its payload SHALL be held stable until then.
REQ-021 B or R arriving with an unexpected ID SHALL still complete the transaction, and m_r_last_i SHALL be ignored.

Reset
REQ-022 Reset SHALL clear all outputs to 0 and set the FSM to IDLE, the grant pointer to 1 and the captured registers to 0.
REQ-023 Reset asserted mid-transaction SHALL drop the transaction with no rsp pulse, and the outputs SHALL clear asynchronously.

Configuration
REQ-024 With macro AXI_TXN_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority with req0 always winning; when undefined, it SHALL be round-robin per REQ-013.

Verification
REQ-025 Single write: req0 we=1, addr=0x1000, wdata=0xDEADBEEF, strb=0xFF, zero-wait slave with OKAY -> AW/W at T+1 with id=0, rsp0_valid at T+3, err=0.
REQ-026 Single read: req1 addr=0x2000, slave returns R data=0x0123456789ABCDEF with OKAY -> AR id=1, rsp1_rdata=0x0123456789ABCDEF, err=0.
REQ-027 Contention: both requesters hold valid for 4 transactions -> grant order 0,1,0,1; with AXI_TXN_ARB_FIXED_PRIO_EN defined -> 0,0,0,0.
REQ-028 Write-channel skew: AW ready delayed 3 cycles with W ready immediately, then the reverse case -> each valid is held until its own handshake, B is awaited only after both, and exactly one rsp pulse is produced.
REQ-029 Error and reset: slave returns SLVERR (2'b10) -> err=1; rst_ni asserted while in RD_RESP -> all outputs 0, no rsp pulse, and the next request after reset completes normally.
